// File: rtl/rx_sync_pkg.sv
// rx_sync_pkg: shared state encoding and K28.5 comma patterns for the word-sync controller
package rx_sync_pkg;
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    SLIP = 3'd1,
    ACQ  = 3'd2,
    SYNC = 3'd3
  } sync_state_t;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
endpackage

// File: rtl/rx_comma_detect.sv
// rx_comma_detect: registered K28.5 (either disparity) match on a raw 10-bit word
// Ports: i_clk word clock, i_rst_n async active-low reset,
//        i_word raw SIPO word, o_comma high one cycle after a comma word.
module rx_comma_detect
  import rx_sync_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_word,
  output logic       o_comma
);
  logic r_comma;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_comma <= 1'b0;
    else          r_comma <= (i_word == K28_5_RDN) || (i_word == K28_5_RDP);
  assign o_comma = r_comma;
endmodule

// File: rtl/rx_word_sync_ctrl.sv
// rx_word_sync_ctrl: 8b/10b receive word alignment (bit slip) and hysteretic link-sync FSM
// Ports: BitCLK_10 word clock, Reset async active-low, RxParallel_10 raw word (bit 9 first),
//        Decode_Error/Disparity_Error decoder flags lagging the word by one clock,
//        Bit_Slip one-cycle slip request, Link_Up high in SYNC, Sync_State FSM code,
//        Err_Count saturating error count (only when RX_SYNC_ERR_COUNT_EN is defined, else 0).
module rx_word_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int HUNT_WINDOW  = 16,
  parameter int SLIP_WAIT    = 4,
  parameter int COMMA_COUNT  = 3,
  parameter int ERR_THRESH   = 4,
  parameter int GOOD_RECOVER = 8
) (
  input  logic        BitCLK_10,
  input  logic        Reset,
  input  logic [9:0]  RxParallel_10,
  input  logic        Decode_Error,
  input  logic        Disparity_Error,
  output logic        Bit_Slip,
  output logic        Link_Up,
  output logic [2:0]  Sync_State,
  output logic [15:0] Err_Count
);
  localparam int HW_W = $clog2(HUNT_WINDOW);
  localparam int SW_W = $clog2(SLIP_WAIT + 1);
  localparam int GC_W = $clog2(COMMA_COUNT + 1);
  localparam int EC_W = $clog2(ERR_THRESH + 1);
  localparam int GR_W = $clog2(GOOD_RECOVER + 1);
  logic            w_comma;
  logic            w_err;
  sync_state_t     r_state;
  logic [HW_W-1:0] r_hunt_cnt;
  logic [SW_W-1:0] r_wait_cnt;
  logic [GC_W-1:0] r_good_cnt;
  logic [EC_W-1:0] r_err_cnt;
  logic [GR_W-1:0] r_good_run;
  logic            r_bit_slip;
  logic            r_link_up;
  // comma_q is registered, so it lines up with the decoder flags for the same word
  rx_comma_detect u_comma (
    .i_clk   (BitCLK_10),
    .i_rst_n (Reset),
    .i_word  (RxParallel_10),
    .o_comma (w_comma)
  );
  assign w_err = Decode_Error | Disparity_Error;
  always_ff @(posedge BitCLK_10 or negedge Reset)
    if (!Reset) begin
      r_state    <= HUNT;
      r_hunt_cnt <= '0;
      r_wait_cnt <= '0;
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
      r_good_run <= '0;
      r_bit_slip <= 1'b0;
      r_link_up  <= 1'b0;
    end else begin
      r_bit_slip <= 1'b0;
      r_link_up  <= 1'b0;
      case (r_state)
        HUNT:
          if (w_comma && !w_err) begin
            r_state    <= ACQ;
            r_good_cnt <= GC_W'(1);
            r_hunt_cnt <= '0;
          end else if (r_hunt_cnt == HW_W'(HUNT_WINDOW - 1)) begin
            r_state    <= SLIP;
            r_hunt_cnt <= '0;
            r_wait_cnt <= '0;
            r_bit_slip <= 1'b1;
          end else r_hunt_cnt <= r_hunt_cnt + HW_W'(1);
        SLIP:
          if (r_wait_cnt == SW_W'(SLIP_WAIT - 1)) begin
            r_state    <= HUNT;
            r_wait_cnt <= '0;
          end else r_wait_cnt <= r_wait_cnt + SW_W'(1);
        ACQ:
          if (w_err) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_hunt_cnt <= '0;
          end else if (w_comma) begin
            // the HUNT comma already counted as one, so compare against COMMA_COUNT-1
            if (r_good_cnt >= GC_W'(COMMA_COUNT - 1)) begin
              r_state    <= SYNC;
              r_good_cnt <= '0;
              r_err_cnt  <= '0;
              r_good_run <= '0;
            end else r_good_cnt <= r_good_cnt + GC_W'(1);
          end
        SYNC:
          if (w_err) begin
            r_good_run <= '0;
            if (r_err_cnt == EC_W'(ERR_THRESH - 1)) begin
              r_state    <= HUNT;
              r_err_cnt  <= '0;
              r_hunt_cnt <= '0;
            end else begin
              r_err_cnt <= r_err_cnt + EC_W'(1);
              r_link_up <= 1'b1;
            end
          end else begin
            r_link_up  <= 1'b1;
            r_good_run <= (r_good_run == GR_W'(GOOD_RECOVER - 1)) ? '0 : r_good_run + GR_W'(1);
            if (r_good_run == GR_W'(GOOD_RECOVER - 1))
              r_err_cnt <= (r_err_cnt == '0) ? '0 : r_err_cnt - EC_W'(1);
          end
        default: begin
          r_state    <= HUNT;
          r_hunt_cnt <= '0;
          r_wait_cnt <= '0;
          r_good_cnt <= '0;
          r_err_cnt  <= '0;
          r_good_run <= '0;
        end
      endcase
    end
  assign Bit_Slip   = r_bit_slip;
  assign Link_Up    = r_link_up;
  assign Sync_State = r_state;
`ifdef RX_SYNC_ERR_COUNT_EN
  logic [15:0] r_err_total;
  always_ff @(posedge BitCLK_10 or negedge Reset)
    if (!Reset) r_err_total <= '0;
    else if (w_err && (r_state == ACQ || r_state == SYNC) && r_err_total != 16'hFFFF)
      r_err_total <= r_err_total + 16'd1;
  assign Err_Count = r_err_total;
`else
  assign Err_Count = 16'h0000;
`endif
endmodule

// File: tb/tb_rx_word_sync_ctrl.sv
// tb_rx_word_sync_ctrl: directed self-checking bench with a bit-level SIPO model honouring Bit_Slip
module tb_rx_word_sync_ctrl;
  import rx_sync_pkg::*;
`ifdef RX_SYNC_ERR_COUNT_EN
  localparam int ET = 100000;
`else
  localparam int ET = 4;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rx = '0;
  logic        dec = 1'b0;
  logic        disp = 1'b0;
  logic        slip;
  logic        up;
  logic [2:0]  st;
  logic [15:0] ecnt;
  int checks = 0;
  int errors = 0;
  int s = 0;
  int n = 0;
  int nslip = 0;
  int last_slip = -1;
  always #5 clk = ~clk;
  rx_word_sync_ctrl #(.ERR_THRESH(ET)) u_dut (
    .BitCLK_10       (clk),
    .Reset           (rst_n),
    .RxParallel_10   (rx),
    .Decode_Error    (dec),
    .Disparity_Error (disp),
    .Bit_Slip        (slip),
    .Link_Up         (up),
    .Sync_State      (st),
    .Err_Count       (ecnt)
  );
  function automatic logic [9:0] aw(int k);
    return (k % 4 == 0) ? K28_5_RDN : 10'b1010101010;
  endfunction
  function automatic logic [9:0] win(int p);
    logic [9:0] w;
    for (int j = 0; j < 10; j++) begin
      logic [9:0] a;
      a = aw((p + j) / 10);
      w[9 - j] = a[9 - ((p + j) % 10)];
    end
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // error flags given to a step describe the word driven in the previous step
  task automatic step(input logic e_dec, input logic e_disp);
    rx = win(s);
    dec = e_dec;
    disp = e_disp;
    @(posedge clk);
    #1;
    if (slip) begin
      if (last_slip >= 0) chk("slip_gap", n - last_slip, 20);
      last_slip = n;
      nslip++;
      s++;
    end
    s += 10;
    n++;
  endtask
  task automatic do_reset(input int s0);
    rst_n = 1'b0;
    rx = '0;
    dec = 1'b0;
    disp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s = s0;
    n = 0;
    nslip = 0;
    last_slip = -1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk("rst_state", st, 0);
    chk("rst_up", up, 0);
    chk("rst_slip", slip, 0);
    chk("rst_ecnt", ecnt, 0);
`ifdef RX_SYNC_ERR_COUNT_EN
    do_reset(0);
    repeat (10) step(0, 0);
    chk("sat_sync", st, 3);
    repeat (100) step(1, 0);
    chk("ecnt_100", ecnt, 100);
    repeat (69900) step(1, 0);
    chk("ecnt_sat", ecnt, 16'hFFFF);
    chk("sat_up", up, 1);
    repeat (5) step(1, 0);
    chk("ecnt_hold", ecnt, 16'hFFFF);
`else
    do_reset(0);
    step(0, 0);
    chk("hunt_w0", st, 0);
    step(0, 0);
    chk("acq_enter", st, 2);
    repeat (7) step(0, 0);
    chk("acq_hold", st, 2);
    step(0, 0);
    chk("sync_enter", st, 3);
    repeat (2) step(0, 0);
    chk("link_up", up, 1);
    chk("aligned_noslip", nslip, 0);
    repeat (2) step(1, 0);
    step(0, 1);
    chk("err3_state", st, 3);
    chk("err3_up", up, 1);
    step(1, 0);
    chk("err4_state", st, 0);
    chk("err4_up", up, 0);
    chk("ecnt_zero", ecnt, 0);
    do_reset(0);
    repeat (12) step(0, 0);
    chk("resync", st, 3);
    for (int r = 0; r < 10; r++) begin
      step(1, 0);
      repeat (8) step(0, 0);
      chk("forgive_up", up, 1);
    end
    for (int r = 0; r < 3; r++) begin
      step(1, 0);
      if (r < 2) repeat (7) step(0, 0);
    end
    chk("no_forgive_err3", up, 1);
    repeat (7) step(0, 0);
    step(1, 0);
    chk("no_forgive_err4", up, 0);
    do_reset(0);
    repeat (2) step(0, 0);
    chk("acq2_enter", st, 2);
    repeat (4) step(0, 0);
    chk("acq2_good2", st, 2);
    repeat (3) step(0, 0);
    step(0, 1);
    chk("acq_disp_hunt", st, 0);
    repeat (4) step(0, 0);
    chk("reacq", st, 2);
    repeat (7) step(0, 0);
    chk("acq_needs3", st, 2);
    step(0, 0);
    chk("acq_third", st, 3);
    do_reset(7);
    for (int i = 0; i < 200 && st != 3; i++) step(0, 0);
    chk("misalign_sync", st, 3);
    chk("misalign_slips", nslip, 3);
    repeat (30) step(0, 0);
    chk("post_align_slips", nslip, 3);
    chk("post_align_up", up, 1);
    chk("ecnt_zero2", ecnt, 0);
    do_reset(7);
    for (int i = 0; i < 40 && !slip; i++) step(0, 0);
    chk("slip_seen", slip, 1);
    chk("slip_state", st, 1);
    rst_n = 1'b0;
    #1;
    chk("slip_async_clear", slip, 0);
    chk("slip_rst_state", st, 0);
    rst_n = 1'b1;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_word_sync_ctrl.md
Name: rx_word_sync_ctrl

Overview:
- Receive-side word-alignment and link-synchronisation controller for the 8b/10b serial link.
- Sits between SIPO and decoder on the recovered word clock:
  - watches raw 10-bit words for K28.5 commas and decoder error flags;
  - drives a bit-slip request back to SIPO until commas land on the word boundary;
  - declares link up or down with a hysteretic error-count state machine.

Parameters:
- HUNT_WINDOW, 16: words checked at one alignment before a slip is requested (>=2).
- SLIP_WAIT, 4: blanking words after a slip before comma checking resumes (>=1).
- COMMA_COUNT, 3: consecutive-error-free commas needed in ACQ to enter SYNC (>=1).
- ERR_THRESH, 4: error budget in SYNC; reaching it drops the link (>=1).
- GOOD_RECOVER, 8: consecutive clean words in SYNC that forgive one error (>=1).

Ports:
- BitCLK_10, input, 1: recovered word clock (one edge per 10-bit word).
- Reset, input, 1: asynchronous, active-low reset.
- RxParallel_10, input, 10: raw word from SIPO; bit [9] is the first received bit (a).
- Decode_Error, input, 1: decoder invalid-code flag. It is registered and lags RxParallel_10 by one BitCLK_10.
- Disparity_Error, input, 1: decoder running-disparity flag, same timing as Decode_Error.
- Bit_Slip, output, 1: one-cycle pulse; SIPO shifts the word boundary by one bit.
- Link_Up, output, 1: high only in SYNC.
- Sync_State, output, 3: encoded FSM state.
- Err_Count, output, 16: saturating link-error counter (see Optional Feature).

Behaviour:
- Comma detect:
  - comma_q is registered: 1 if the previous-cycle RxParallel_10 equals 10'b0011111010 or 10'b1100000101.
  - err_w = Decode_Error | Disparity_Error.
  - comma_q and err_w therefore refer to the same word in the same cycle.
- Reset (async, Reset=0):
  - state=HUNT; all counters 0; comma_q=0.
  - Bit_Slip=0, Link_Up=0, Sync_State=3'd0, Err_Count=0.
- State encoding: HUNT=0, SLIP=1, ACQ=2, SYNC=3. Codes 4-7 are illegal and recover to HUNT on the next edge.
- HUNT:
  - comma_q & !err_w -> ACQ with good_cnt=1, hunt_cnt=0.
  - Otherwise hunt_cnt++. When hunt_cnt==HUNT_WINDOW-1 on a non-comma word -> SLIP with hunt_cnt=0.
- SLIP:
  - Bit_Slip=1 on the first SLIP cycle only.
  - Input is ignored for SLIP_WAIT cycles (wait_cnt 0..SLIP_WAIT-1), then -> HUNT.
  - A comma during SLIP is ignored.
- ACQ:
  - err_w=1 -> HUNT; this has priority over a comma in the same cycle.
  - comma_q & !err_w -> good_cnt++. When good_cnt reaches COMMA_COUNT -> SYNC with err_cnt=0, good_run=0.
  - Clean non-comma words hold state; good_cnt is unchanged.
  - COMMA_COUNT=1 is legal; the HUNT comma then counts, and the FSM enters SYNC on the next comma.
- SYNC:
  - Link_Up=1 (registered; rises the cycle after the SYNC transition edge).
  - err_w=1 -> err_cnt++, good_run=0. When err_cnt+1==ERR_THRESH -> HUNT; Link_Up falls on the same edge.
  - err_w=0 -> good_run++. When good_run reaches GOOD_RECOVER: good_run=0 and err_cnt decrements (floor 0).
  - Commas in SYNC are data; misaligned commas are not checked.
- Bit_Slip is never high for two consecutive cycles.
- Minimum spacing between slips is SLIP_WAIT+HUNT_WINDOW cycles.
- Reset asserted mid-SLIP clears Bit_Slip immediately (asynchronous).
- Sync_State reflects the registered state; all outputs are registered.

Optional Feature:
- Macro RX_SYNC_ERR_COUNT_EN.
- Defined: Err_Count increments by 1 on every err_w=1 cycle in ACQ or SYNC. It saturates at 16'hFFFF and is cleared only by Reset.
- Undefined: Err_Count is tied to 16'h0000; no counter flops are synthesised; the port list is unchanged.

Decomposition:
- Package rx_sync_pkg:
  - sync_state_t enum (3-bit, encodings above);
  - K28_5_RDN=10'b0011111010 and K28_5_RDP=10'b1100000101.
- Sub-module rx_comma_detect: registered 10-bit compare producing comma_q. It is instantiated once.

Test Plan:
- Aligned stream, K28.5 every 4th word, no errors -> Link_Up rises after the 3rd comma seen at ACQ/HUNT; no Bit_Slip pulses.
- Stream offset by 3 bits, commas every 4 words -> exactly 3 Bit_Slip pulses, each ≥20 cycles apart. SYNC follows after alignment.
- In SYNC, 4 error words within 8 cycles -> Link_Up falls on the 4th error edge; Sync_State=0.
- In SYNC, error / 8 clean words / error, repeated 10 times -> err_cnt never exceeds 1; Link_Up stays 1.
- In ACQ after 2 commas, a comma word with Disparity_Error=1 -> HUNT, and 3 fresh commas are required.
- Macro defined: 70000 error words -> Err_Count=16'hFFFF, held. Macro undefined: Err_Count=0 throughout.
